// File: rtl/decode_execute_register_pkg.sv
// Shared core package: decoded control bundle and its field encodings, used by the
// decoder, the decode/execute register and the execute stage.
package decode_execute_register_pkg;

    typedef enum logic [1:0] {
        ResultAlu = 2'b00,
        ResultMem = 2'b01,
        ResultPc4 = 2'b10
    } result_src_e;

    typedef enum logic [2:0] {
        AluAdd = 3'b000,
        AluSub = 3'b001,
        AluAnd = 3'b010,
        AluOr  = 3'b011,
        AluSlt = 3'b101
    } alu_ctrl_e;

    typedef struct packed {
        logic       reg_write;
        logic [1:0] result_src;
        logic       mem_write;
        logic       branch;
        logic       jump;
        logic [2:0] alu_ctrl;
        logic       alu_src;
    } ctrl_t;

    // All-zero controls: no register write, no store, no redirect.
    localparam ctrl_t CtrlBubble = '0;

endpackage

// File: rtl/decode_execute_register_if.sv
// Decode-to-execute pipeline bundle: decode-side fields, hazard controls and the
// registered execute-side copies.
interface decode_execute_register_if #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 32
) ();
    import decode_execute_register_pkg::*;

    logic            valid_d;
    ctrl_t           ctrl_d;
    logic [XLEN-1:0] rd1_d, rd2_d, pc_d, pc_plus4_d, imm_ext_d;
    logic [4:0]      rs1_d, rs2_d, rd_d;
    logic            stall_e;
    logic            flush_e;

    logic             valid_e;
    ctrl_t            ctrl_e;
    logic [XLEN-1:0]  rd1_e, rd2_e, pc_e, pc_plus4_e, imm_ext_e;
    logic [4:0]       rs1_e, rs2_e, rd_e;
    logic [CNT_W-1:0] bubble_count;

    modport master (
        output valid_d, ctrl_d, rd1_d, rd2_d, pc_d, pc_plus4_d, imm_ext_d,
               rs1_d, rs2_d, rd_d, stall_e, flush_e,
        input  valid_e, ctrl_e, rd1_e, rd2_e, pc_e, pc_plus4_e, imm_ext_e,
               rs1_e, rs2_e, rd_e, bubble_count
    );

    modport slave (
        input  valid_d, ctrl_d, rd1_d, rd2_d, pc_d, pc_plus4_d, imm_ext_d,
               rs1_d, rs2_d, rd_d, stall_e, flush_e,
        output valid_e, ctrl_e, rd1_e, rd2_e, pc_e, pc_plus4_e, imm_ext_e,
               rs1_e, rs2_e, rd_e, bubble_count
    );

endinterface

// File: rtl/decode_execute_register.sv
// Decode/execute pipeline register with stall hold, flush-to-bubble and a saturating
// count of bubbles inserted since reset.
module decode_execute_register
    import decode_execute_register_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 32
) (
    input logic                      clk,
    input logic                      rst,
    decode_execute_register_if.slave bus
);

    localparam logic [XLEN-1:0]  DataZero = '0;
    localparam logic [CNT_W-1:0] CntMax   = '1;

    // An edge produces a bubble when flushed, or when loading a non-instruction.
    logic bubble;
    assign bubble = bus.flush_e | (~bus.stall_e & ~bus.valid_d);

    always_ff @(posedge clk or posedge rst) begin
        if (rst || bus.flush_e) begin
            bus.valid_e    <= 1'b0;
            bus.ctrl_e     <= CtrlBubble;
            bus.rd1_e      <= DataZero;
            bus.rd2_e      <= DataZero;
            bus.pc_e       <= DataZero;
            bus.pc_plus4_e <= DataZero;
            bus.imm_ext_e  <= DataZero;
            bus.rs1_e      <= 5'd0;
            bus.rs2_e      <= 5'd0;
            bus.rd_e       <= 5'd0;
        end else if (!bus.stall_e) begin
            bus.valid_e    <= bus.valid_d;
            bus.ctrl_e     <= bus.valid_d ? bus.ctrl_d : CtrlBubble;
            bus.rd1_e      <= bus.rd1_d;
            bus.rd2_e      <= bus.rd2_d;
            bus.pc_e       <= bus.pc_d;
            bus.pc_plus4_e <= bus.pc_plus4_d;
            bus.imm_ext_e  <= bus.imm_ext_d;
            bus.rs1_e      <= bus.rs1_d;
            bus.rs2_e      <= bus.rs2_d;
            bus.rd_e       <= bus.rd_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.bubble_count <= '0;
        end else if (bubble && (bus.bubble_count != CntMax)) begin
            bus.bubble_count <= bus.bubble_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_decode_execute_register.sv
// Scoreboard bench: random and directed pipeline traffic predicted by a behavioural
// model, plus async-reset and counter-saturation checks on a narrow-counter instance.
module tb_decode_execute_register;
    import decode_execute_register_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    decode_execute_register_if #(.XLEN(32), .CNT_W(32)) bus ();
    decode_execute_register_if #(.XLEN(32), .CNT_W(4))  bus4 ();

    decode_execute_register #(.XLEN(32), .CNT_W(32)) dut (.clk(clk), .rst(rst), .bus(bus));
    decode_execute_register #(.XLEN(32), .CNT_W(4))  dut4 (.clk(clk), .rst(rst), .bus(bus4));

    typedef struct packed {
        logic        valid;
        ctrl_t       ctrl;
        logic [31:0] rd1, rd2, pc, pc4, imm;
        logic [4:0]  rs1, rs2, rd;
        logic        stall, flush;
    } in_t;

    typedef struct packed {
        logic        valid;
        ctrl_t       ctrl;
        logic [31:0] rd1, rd2, pc, pc4, imm;
        logic [4:0]  rs1, rs2, rd;
        logic [31:0] cnt;
    } obs_t;

    obs_t        exp_q[$];
    obs_t        model;
    int unsigned vectors     = 0;
    int unsigned miscompares = 0;

    // Reference: what the execute stage should hold after one edge.
    function automatic obs_t predict(obs_t prev, in_t in);
        obs_t n;
        longint unsigned c;
        bit is_bubble;
        n = prev;
        is_bubble = 1'b0;
        if (in.flush) begin
            n = '0;
            is_bubble = 1'b1;
        end else if (!in.stall) begin
            n.valid = in.valid;
            n.ctrl  = in.valid ? in.ctrl : ctrl_t'(10'd0);
            n.rd1 = in.rd1; n.rd2 = in.rd2; n.pc = in.pc; n.pc4 = in.pc4; n.imm = in.imm;
            n.rs1 = in.rs1; n.rs2 = in.rs2; n.rd = in.rd;
            is_bubble = !in.valid;
        end
        c = prev.cnt;
        if (is_bubble && c < 64'hFFFF_FFFF) c = c + 1;
        n.cnt = c[31:0];
        return n;
    endfunction

    function automatic obs_t sample();
        obs_t s;
        s.valid = bus.valid_e; s.ctrl = bus.ctrl_e;
        s.rd1 = bus.rd1_e; s.rd2 = bus.rd2_e; s.pc = bus.pc_e;
        s.pc4 = bus.pc_plus4_e; s.imm = bus.imm_ext_e;
        s.rs1 = bus.rs1_e; s.rs2 = bus.rs2_e; s.rd = bus.rd_e;
        s.cnt = bus.bubble_count;
        return s;
    endfunction

    task automatic check_obs(string name, obs_t a, obs_t e);
        vectors++;
        if (a !== e) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, a, e);
        end
    endtask

    task automatic check_val(string name, logic [31:0] a, logic [31:0] e);
        vectors++;
        if (a !== e) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, a, e);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) check_obs("pipe", sample(), exp_q.pop_front());
    end

    task automatic apply(in_t in);
        bus.valid_d = in.valid; bus.ctrl_d = in.ctrl;
        bus.rd1_d = in.rd1; bus.rd2_d = in.rd2; bus.pc_d = in.pc;
        bus.pc_plus4_d = in.pc4; bus.imm_ext_d = in.imm;
        bus.rs1_d = in.rs1; bus.rs2_d = in.rs2; bus.rd_d = in.rd;
        bus.stall_e = in.stall; bus.flush_e = in.flush;
        @(posedge clk);
        model = predict(model, in);
        exp_q.push_back(model);
        #1;
    endtask

    task automatic drive(in_t in);
        @(negedge clk);
        apply(in);
    endtask

    function automatic in_t rand_in();
        in_t r;
        r.valid = ($urandom_range(3) != 0);
        r.ctrl  = ctrl_t'(10'($urandom));
        r.rd1 = $urandom; r.rd2 = $urandom; r.pc = $urandom;
        r.pc4 = $urandom; r.imm = $urandom;
        r.rs1 = 5'($urandom); r.rs2 = 5'($urandom); r.rd = 5'($urandom);
        r.stall = ($urandom_range(3) == 0);
        r.flush = ($urandom_range(7) == 0);
        return r;
    endfunction

    initial begin
        in_t v;
        rst = 1'b1;
        v = '0;
        v.stall = 1'b1;
        bus.valid_d = 0; bus.ctrl_d = '0; bus.rd1_d = 0; bus.rd2_d = 0; bus.pc_d = 0;
        bus.pc_plus4_d = 0; bus.imm_ext_d = 0; bus.rs1_d = 0; bus.rs2_d = 0; bus.rd_d = 0;
        bus.stall_e = 1'b1; bus.flush_e = 1'b0;
        bus4.valid_d = 0; bus4.ctrl_d = '0; bus4.rd1_d = 0; bus4.rd2_d = 0; bus4.pc_d = 0;
        bus4.pc_plus4_d = 0; bus4.imm_ext_d = 0; bus4.rs1_d = 0; bus4.rs2_d = 0; bus4.rd_d = 0;
        bus4.stall_e = 1'b1; bus4.flush_e = 1'b0;
        model = '0;
        #12;
        check_obs("reset", sample(), '0);
        @(negedge clk);
        rst = 1'b0;

        // Plain load of a valid instruction.
        v = '0;
        v.valid = 1'b1; v.ctrl.reg_write = 1'b1; v.ctrl.alu_ctrl = AluAnd;
        v.rd1 = 32'h5; v.rd = 5'd7;
        drive(v);
        check_val("load_valid", 32'(bus.valid_e), 32'd1);
        check_val("load_alu", 32'(bus.ctrl_e.alu_ctrl), 32'd2);
        check_val("load_rd1", bus.rd1_e, 32'd5);
        check_val("load_rd", 32'(bus.rd_e), 32'd7);

        for (int i = 0; i < 3; i++) begin
            v = rand_in(); v.stall = 1'b1; v.flush = 1'b0;
            drive(v);
            check_val("stall_rd1", bus.rd1_e, 32'd5);
            check_val("stall_cnt", bus.bubble_count, 32'd0);
        end

        v = rand_in(); v.stall = 1'b1; v.flush = 1'b1;
        drive(v);
        check_val("flush_ctrl", 32'(bus.ctrl_e), 32'd0);
        check_val("flush_cnt", bus.bubble_count, 32'd1);

        v = rand_in(); v.valid = 1'b0; v.ctrl.mem_write = 1'b1; v.imm = 32'h10;
        v.stall = 1'b0; v.flush = 1'b0;
        drive(v);
        check_val("inv_memwr", 32'(bus.ctrl_e.mem_write), 32'd0);
        check_val("inv_imm", bus.imm_ext_e, 32'h10);
        check_val("inv_cnt", bus.bubble_count, 32'd2);

        v = rand_in(); v.flush = 1'b1;
        drive(v);
        v = rand_in(); v.valid = 1'b1; v.stall = 1'b0; v.flush = 1'b0;
        drive(v);
        check_val("pre_rst_valid", 32'(bus.valid_e), 32'd1);
        check_val("pre_rst_cnt", bus.bubble_count, 32'd3);

        // Asynchronous reset between edges, then a load on the following edge.
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        check_obs("async_rst", sample(), '0);
        rst = 1'b0;
        model = '0;
        v = rand_in(); v.valid = 1'b1; v.stall = 1'b0; v.flush = 1'b0;
        apply(v);
        check_val("post_rst_valid", 32'(bus.valid_e), 32'd1);
        check_val("post_rst_cnt", bus.bubble_count, 32'd0);

        for (int i = 0; i < 400; i++) drive(rand_in());

        v = '0; v.stall = 1'b1;
        drive(v);
        @(negedge clk);
        @(negedge clk);

        // Saturation on the 4-bit counter instance.
        #1;
        rst = 1'b1;
        #1;
        check_val("sat_rst", 32'(bus4.bubble_count), 32'd0);
        bus4.flush_e = 1'b1;
        rst = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            check_val("sat_cnt", 32'(bus4.bubble_count), (i > 15) ? 32'd15 : 32'(i));
        end
        bus4.flush_e = 1'b0;
        @(posedge clk);
        #1;
        check_val("sat_stall", 32'(bus4.bubble_count), 32'd15);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/decode_execute_register.md
DECODE_EXECUTE_REGISTER -- requirements
Module: decode_execute_register

Interface
REQ-001 Parameter: XLEN, default 32, datapath width.
REQ-002 Parameter: CNT_W, default 32, bubble-counter width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 valid_d  input  1  decode stage holds a real instruction.
REQ-006 ctrl_d  input  ctrl_t  decoded controls: reg_write, result_src[1:0], mem_write, branch, jump, alu_ctrl[2:0], alu_src.
REQ-007 rd1_d, rd2_d  input  XLEN each  register-file read data.
REQ-008 pc_d, pc_plus4_d, imm_ext_d  input  XLEN each  PC, PC+4, extended immediate.
REQ-009 rs1_d, rs2_d, rd_d  input  5 each  source/destination register indices.
REQ-010 stall_e  input  1  hold current execute-stage contents.
REQ-011 flush_e  input  1  replace execute-stage contents with a bubble.
REQ-012 valid_e, ctrl_e, rd1_e, rd2_e, pc_e, pc_plus4_e, imm_ext_e, rs1_e, rs2_e, rd_e  output  widths as above  registered copies for execute stage.
REQ-013 bubble_count  output  CNT_W  number of bubbles inserted since reset.

Function
REQ-014 Latency exactly one cycle: inputs sampled at edge N appear on outputs after edge N.
REQ-015 Priority per edge: flush_e > stall_e > normal load.
REQ-016 Normal load (flush_e=0, stall_e=0): all outputs take the corresponding _d values.
REQ-017 Stall (stall_e=1, flush_e=0): every output holds its value; bubble_count unchanged.
REQ-018 Flush (flush_e=1, with or without stall_e): valid_e=0, every ctrl_e field=0, rd_e/rs1_e/rs2_e=0; data fields (rd1_e, rd2_e, pc_e, pc_plus4_e, imm_ext_e) SHALL be zero.
REQ-019 Load with valid_d=0 SHALL also be treated as a bubble: ctrl_e fields and valid_e forced to 0, data fields loaded normally.
REQ-020 Bubble: ctrl_e.reg_write=0 and ctrl_e.mem_write=0 so no architectural side effect; branch and jump 0 so no redirect.
REQ-021 bubble_count increments by 1 on every edge whose result is a bubble (REQ-018 or REQ-019), not on stall edges.
REQ-022 bubble_count saturates at all-ones; no wrap-around.
REQ-023 No combinational path from any input to any output.

Reset
REQ-024 Asserting rst immediately (asynchronously) drives all outputs to zero, including valid_e and bubble_count.
REQ-025 Reset mid-stall or mid-flush overrides both; first edge after rst deasserts follows REQ-015 normally.
REQ-026 Reset state counts as a bubble already present and SHALL NOT increment bubble_count.

Structure
REQ-027 ctrl_t (packed struct of REQ-006 fields) and the result_src / alu_ctrl encodings live in the shared core package, used by decoder, this block and execute stage.
REQ-028 Single flat module; no sub-modules; one always block per state group (pipeline fields, counter).

Verification
REQ-029 Load: valid_d=1, ctrl_d.reg_write=1, alu_ctrl=3'b010, rd1_d=32'h0000_0005, rd_d=5'd7 -> next cycle valid_e=1, ctrl_e.reg_write=1, alu_ctrl_e=3'b010, rd1_e=5, rd_e=7.
REQ-030 Stall: after load, stall_e=1 for 3 cycles with changing _d inputs -> outputs unchanged all 3 cycles, bubble_count unchanged.
REQ-031 Flush vs stall: stall_e=1 and flush_e=1 same edge -> valid_e=0, ctrl_e=0, rd_e=0, bubble_count +1.
REQ-032 Invalid decode: valid_d=0, ctrl_d.mem_write=1, imm_ext_d=32'h10 -> ctrl_e.mem_write=0, valid_e=0, imm_ext_e=32'h10, bubble_count +1.
REQ-033 Saturation: CNT_W=4, 20 consecutive flush edges -> bubble_count stops at 4'hF.
REQ-034 Async reset: assert rst between edges while valid_e=1, bubble_count=3 -> outputs 0 before next edge; after release, load resumes on following edge.
